demux16_collect: RTL and testbench

//  Inverse of the ALU 16:1 lane select. Takes N-bit scalars tagged with a 4-bit lane select.

---
 rtl/demux16_collect_if.sv | 37 +++
 rtl/demux16_collect.sv | 106 ++++++++++
 tb/tb_demux16_collect.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux16_collect_if.sv
// Interface bundling the scalar write port, the vector output port and the
// optional duplicate-write flag of demux16_collect.
// Optional feature macro: DEMUX_DUPERR_EN (adds dup_err).
interface demux16_collect_if #(
   parameter int N = 4
);
   logic [N-1:0]    din;
   logic [3:0]      sel;
   logic            in_valid;
   logic            in_ready;
   logic            flush;
   logic [16*N-1:0] vec_out;
   logic [15:0]     lane_mask;
   logic            out_valid;
   logic            out_ready;
`ifdef DEMUX_DUPERR_EN
   logic            dup_err;
`endif

   // Producer/consumer side (testbench or surrounding datapath)
   modport master (
      output din, sel, in_valid, flush, out_ready,
      input  in_ready, vec_out, lane_mask, out_valid
`ifdef DEMUX_DUPERR_EN
      , input dup_err
`endif
   );

   // Collector side
   modport slave (
      input  din, sel, in_valid, flush, out_ready,
      output in_ready, vec_out, lane_mask, out_valid
`ifdef DEMUX_DUPERR_EN
      , output dup_err
`endif
   );
endinterface

// File: rtl/demux16_collect.sv
// demux16_collect: scatters lane-tagged scalars into 16 lane registers and
// presents the assembled vector when all lanes are written or on flush.
// Optional feature macro: DEMUX_DUPERR_EN (sticky duplicate-write flag).
module demux16_collect #(
   parameter int N = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   demux16_collect_if.slave   bus
);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [15:0]     mask_q, mask_d;
   logic            wr_accept;
   logic            emit_done;
   logic [16*N-1:0] vec_w;

   // Next-state, handshake outputs and post-write mask
   always_comb begin
      state_d       = state_q;
      mask_d        = mask_q;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      wr_accept     = 1'b0;
      emit_done     = 1'b0;
      case (state_q)
         COLLECT: begin
            bus.in_ready = 1'b1;
            wr_accept    = bus.in_valid;
            if (wr_accept)
               mask_d = mask_q | (16'b1 << bus.sel);
            // The flush decision looks at the mask including this cycle's write
            if (mask_d == 16'hFFFF || (bus.flush && mask_d != 16'h0000))
               state_d = HOLD;
         end
         HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               emit_done = 1'b1;
               mask_d    = 16'h0000;
               state_d   = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // State and mask registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= COLLECT;
         mask_q  <= 16'h0000;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
      end
   end

   // One register per lane; each loads on a write to its own index and
   // clears when the held vector is taken.
   for (genvar gi = 0; gi < 16; gi++) begin : gen_lane
      logic [N-1:0] lane_q;

      // Lane storage update
      always_ff @(posedge clk) begin
         if (!rst_n)
            lane_q <= '0;
         else if (emit_done)
            lane_q <= '0;
         else if (wr_accept && bus.sel == 4'(gi))
            lane_q <= bus.din;
      end

      assign vec_w[gi*N +: N] = lane_q;
   end

   // Output is the raw register contents in every state
   assign bus.vec_out   = vec_w;
   assign bus.lane_mask = mask_q;

`ifdef DEMUX_DUPERR_EN
   logic dup_q, dup_d;

   // Sticky flag: set on a write to an already-written lane, cleared on emit
   always_comb begin
      dup_d = dup_q;
      if (emit_done)
         dup_d = 1'b0;
      else if (wr_accept && mask_q[bus.sel])
         dup_d = 1'b1;
   end

   // Duplicate flag register
   always_ff @(posedge clk) begin
      if (!rst_n)
         dup_q <= 1'b0;
      else
         dup_q <= dup_d;
   end

   assign bus.dup_err = dup_q;
`endif

endmodule

// File: tb/tb_demux16_collect.sv
// Self-checking bench for demux16_collect (N=4): directed scenarios plus a
// randomized run against a transaction-level reference model.
// Optional feature macro: DEMUX_DUPERR_EN (dup_err checks).
module tb_demux16_collect;
   localparam int N = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   demux16_collect_if #(.N(N)) bus ();

   demux16_collect #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: lane contents, written-set, holding flag, duplicate flag
   logic [3:0]  m_lane [16];
   logic [15:0] m_mask;
   bit          m_hold;
   bit          m_dup;

   function automatic logic [63:0] model_vec();
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i*4 +: 4] = m_lane[i];
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_lane[i] = '0;
      m_mask = '0;
      m_hold = 0;
      m_dup  = 0;
   endtask

   // One clock of the model, given the inputs present at that edge
   task automatic model_step(input bit v, input logic [3:0] s, input logic [3:0] d,
                             input bit f, input bit ordy);
      if (!m_hold) begin
         if (v) begin
            if (m_mask[s]) m_dup = 1;
            m_lane[s] = d;
            m_mask[s] = 1'b1;
         end
         if (m_mask == 16'hFFFF || (f && m_mask != 0)) m_hold = 1;
      end else if (ordy) begin
         model_reset();
      end
   endtask

   // Drive inputs, take one edge, update the model, settle past the edge
   task automatic cycle(input bit v, input logic [3:0] s, input logic [3:0] d,
                        input bit f, input bit ordy);
      bus.in_valid  = v;
      bus.sel       = s;
      bus.din       = d;
      bus.flush     = f;
      bus.out_ready = ordy;
      @(posedge clk);
      model_step(v, s, d, f, ordy);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cycle(0, 0, 0, 0, 0);
      model_reset();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      // Dirty some state first so reset has something to discard
      rst_n = 1'b1;
      cycle(1, 4'd5, 4'h9, 0, 0);
      do_reset();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.lane_mask !== 16'h0 || bus.vec_out !== 64'h0) begin
         errors++;
         $display("FAIL reset: in_ready=%b out_valid=%b mask=%h vec=%h, required 1 0 0000 0", bus.in_ready, bus.out_valid, bus.lane_mask, bus.vec_out);
      end
`ifdef DEMUX_DUPERR_EN
      checks++;
      if (bus.dup_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_dup: dup_err=%b, required 0", bus.dup_err);
      end
`endif
      $display("test_reset done");
   endtask

   task automatic test_full_fill();
      for (int i = 0; i < 16; i++) begin
         cycle(1, 4'(i), 4'(i), 0, 0);
         if (i == 14) begin
            checks++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
               errors++;
               $display("FAIL fill_early: out_valid=%b in_ready=%b after 15 writes, required 0 1", bus.out_valid, bus.in_ready);
            end
         end
      end
      checks++;
      if (bus.out_valid !== 1'b1 || bus.vec_out !== 64'hFEDCBA9876543210 || bus.lane_mask !== 16'hFFFF || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL fill: out_valid=%b vec=%h mask=%h in_ready=%b, required 1 fedcba9876543210 ffff 0", bus.out_valid, bus.vec_out, bus.lane_mask, bus.in_ready);
      end
      cycle(0, 0, 0, 0, 1);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.lane_mask !== 16'h0 || bus.vec_out !== 64'h0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL fill_emit: out_valid=%b mask=%h vec=%h in_ready=%b, required 0 0000 0 1", bus.out_valid, bus.lane_mask, bus.vec_out, bus.in_ready);
      end
      $display("test_full_fill done");
   endtask

   task automatic test_flush_partial();
      // Flush on an empty mask is ignored
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: out_valid=%b, required 0", bus.out_valid);
      end
      cycle(1, 4'd3, 4'hA, 0, 0);
      checks++;
      if (bus.vec_out !== 64'h000000000000A000 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL write_visible: vec=%h out_valid=%b, required 000000000000a000 0", bus.vec_out, bus.out_valid);
      end
      cycle(0, 0, 0, 1, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.lane_mask !== 16'h0008 || bus.vec_out !== 64'h000000000000A000) begin
         errors++;
         $display("FAIL flush_partial: out_valid=%b mask=%h vec=%h, required 1 0008 000000000000a000", bus.out_valid, bus.lane_mask, bus.vec_out);
      end
      cycle(0, 0, 0, 0, 1);
      $display("test_flush_partial done");
   endtask

   task automatic test_back_pressure();
      logic [63:0] held;
      cycle(1, 4'd0, 4'h3, 1, 0);
      held = bus.vec_out;
      checks++;
      if (held !== 64'h3 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_enter: vec=%h out_valid=%b, required 3 1", held, bus.out_valid);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)), 1, 0);
         checks++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.vec_out !== held || bus.lane_mask !== 16'h0001) begin
            errors++;
            $display("FAIL bp_hold[%0d]: in_ready=%b out_valid=%b vec=%h mask=%h, required 0 1 %h 0001", i, bus.in_ready, bus.out_valid, bus.vec_out, bus.lane_mask, held);
         end
      end
      cycle(1, 4'd7, 4'h6, 0, 1);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.lane_mask !== 16'h0 || bus.in_ready !== 1'b1 || bus.vec_out !== 64'h0) begin
         errors++;
         $display("FAIL bp_release: out_valid=%b mask=%h in_ready=%b vec=%h, required 0 0000 1 0", bus.out_valid, bus.lane_mask, bus.in_ready, bus.vec_out);
      end
      $display("test_back_pressure done");
   endtask

   task automatic test_write_flush();
      cycle(1, 4'd15, 4'h5, 1, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.lane_mask !== 16'h8000 || bus.vec_out !== 64'h5000000000000000) begin
         errors++;
         $display("FAIL write_flush: out_valid=%b mask=%h vec=%h, required 1 8000 5000000000000000", bus.out_valid, bus.lane_mask, bus.vec_out);
      end
      cycle(0, 0, 0, 0, 1);
      $display("test_write_flush done");
   endtask

   task automatic test_duplicate();
      cycle(1, 4'd2, 4'h1, 0, 0);
`ifdef DEMUX_DUPERR_EN
      checks++;
      if (bus.dup_err !== 1'b0) begin
         errors++;
         $display("FAIL dup_first: dup_err=%b, required 0", bus.dup_err);
      end
`endif
      cycle(1, 4'd2, 4'h7, 0, 0);
      checks++;
      if (bus.vec_out[11:8] !== 4'h7 || bus.lane_mask !== 16'h0004 || bus.vec_out !== 64'h700) begin
         errors++;
         $display("FAIL dup_data: vec=%h mask=%h, required 0000000000000700 0004", bus.vec_out, bus.lane_mask);
      end
      cycle(0, 0, 0, 1, 0);
`ifdef DEMUX_DUPERR_EN
      checks++;
      if (bus.dup_err !== 1'b1 || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL dup_sticky: dup_err=%b out_valid=%b, required 1 1", bus.dup_err, bus.out_valid);
      end
`endif
      cycle(0, 0, 0, 0, 1);
`ifdef DEMUX_DUPERR_EN
      checks++;
      if (bus.dup_err !== 1'b0) begin
         errors++;
         $display("FAIL dup_clear: dup_err=%b, required 0", bus.dup_err);
      end
`endif
      $display("test_duplicate done");
   endtask

   task automatic test_random();
      bit          v, f, o;
      logic [3:0]  s, d;
      for (int i = 0; i < 400; i++) begin
         v = ($urandom_range(0, 3) != 0);
         f = ($urandom_range(0, 9) == 0);
         o = ($urandom_range(0, 2) == 0);
         s = 4'($urandom_range(0, 15));
         d = 4'($urandom);
         cycle(v, s, d, f, o);
         checks++;
         if (bus.vec_out !== model_vec() || bus.lane_mask !== m_mask || bus.out_valid !== m_hold || bus.in_ready !== !m_hold) begin
            errors++;
            $display("FAIL random[%0d]: vec=%h mask=%h ov=%b ir=%b, required %h %h %b %b", i, bus.vec_out, bus.lane_mask, bus.out_valid, bus.in_ready, model_vec(), m_mask, m_hold, !m_hold);
         end
`ifdef DEMUX_DUPERR_EN
         checks++;
         if (bus.dup_err !== m_dup) begin
            errors++;
            $display("FAIL random_dup[%0d]: dup_err=%b, required %b", i, bus.dup_err, m_dup);
         end
`endif
      end
      // Reset in the middle of a partial fill discards everything
      cycle(1, 4'd9, 4'hC, 0, 1);
      do_reset();
      checks++;
      if (bus.vec_out !== 64'h0 || bus.lane_mask !== 16'h0 || bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: vec=%h mask=%h ov=%b, required 0 0000 0", bus.vec_out, bus.lane_mask, bus.out_valid);
      end
      $display("test_random done");
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.sel       = '0;
      bus.din       = '0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b0;
      model_reset();
      test_reset();
      test_full_fill();
      test_flush_partial();
      test_back_pressure();
      test_write_flush();
      test_duplicate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
